zeroriscy_multdiv_ctrl: RTL and testbench
=========================================

Name: zeroriscy_multdiv_ctrl

Overview:
Issue-side controller for the zero-riscy fast multiply/divide engine. It accepts one RV32M request per handshake from the ID/EX stage and decodes funct3 into the engine's operator and signed-mode encoding. It holds the operands and enable stable until the engine signals ready, then captures the result and offers it to writeback on a valid/ready response channel. It also handles flush and writeback back-pressure, so the engine's internal FSM is never abandoned mid-operation.

Parameters:
CNT_WIDTH, 6, width of the saturating per-operation cycle counter reported on last_cycles_o.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid_i  in  1  upstream request valid
req_ready_o  out  1  controller can accept a request
funct3_i  in  3  RV32M funct3 (000 MUL … 111 REMU)
op_a_i  in  32  rs1 value
op_b_i  in  32  rs2 value
flush_i  in  1  pipeline kill; drop any in-flight or pending result
md_mult_en_o  out  1  engine multiply enable
md_div_en_o  out  1  engine divide enable
md_operator_o  out  2  00 MULL, 01 MULH, 10 DIV, 11 REM
md_signed_mode_o  out  2  bit0 = op_a signed, bit1 = op_b signed
md_op_a_o  out  32  latched op_a
md_op_b_o  out  32  latched op_b
md_b_zero_o  out  1  latched op_b == 0; drives the engine's zero flag
md_result_i  in  32  engine result
md_ready_i  in  1  engine done (single-cycle pulse)
rsp_valid_o  out  1  result valid to writeback
rsp_ready_i  in  1  writeback accepts
rsp_data_o  out  32  result
busy_o  out  1  state != IDLE
last_cycles_o  out  CNT_WIDTH  enable cycles of the last completed operation, saturating

Behaviour:
- States: IDLE, BUSY, DRAIN, RESP. Reset puts the block in IDLE and clears every output register: rsp_data_o=0, last_cycles_o=0, operands=0, operator=0, signed=0. All outputs are 0 in reset.
- Decode (registered at accept):
  - 000 MULL/00
  - 001 MULH/11
  - 010 MULH/01
  - 011 MULH/00
  - 100 DIV/11
  - 101 DIV/00
  - 110 REM/11
  - 111 REMU→REM/00
  - A request is a mult when funct3[2]=0.
- IDLE: req_ready_o=1. If req_valid_i=1 and flush_i=0:
  - latch operands, operator, signed mode and md_b_zero
  - clear the counter
  - go to BUSY
  - If flush_i=1 in the same cycle, the request is not accepted.
- BUSY:
  - Exactly one of md_mult_en_o / md_div_en_o is 1, held continuously. Operands stay stable. req_ready_o=0.
  - The counter increments each cycle and saturates at all-ones.
  - md_ready_i=1 and flush_i=0: rsp_data_o<=md_result_i, last_cycles_o<=counter+1 (saturating), go to RESP.
  - flush_i=1 with md_ready_i=0: go to DRAIN.
  - flush_i=1 with md_ready_i=1 in the same cycle: discard the result, update last_cycles_o, go to IDLE.
- DRAIN:
  - Enables stay asserted, because the engine FSM advances only while enabled.
  - On md_ready_i: discard the result, update last_cycles_o, go to IDLE. flush_i is ignored.
  - rsp_valid_o=0 throughout.
- RESP:
  - rsp_valid_o=1. rsp_data_o is stable until the handshake. Enables are 0.
  - rsp_ready_i=1: go to IDLE. req_ready_o=0 in RESP, so there is no same-cycle re-accept.
  - flush_i=1: drop the response and go to IDLE. flush has priority over rsp_ready_i.
- Timing: md_ready_i is sampled only in BUSY/DRAIN; a ready pulse in IDLE/RESP is ignored. The first enable cycle is the cycle after accept. Minimum request-to-rsp_valid latency is engine latency + 1.
- md_b_zero_o is computed from op_b_i at accept and registered. It is not recomputed from md_op_b_o.

Test Plan:
- MUL a=7, b=6, engine ready after 3 enable cycles → md_operator_o=00, md_mult_en_o high 3 cycles, rsp_data_o=42, last_cycles_o=3.
- MULHSU funct3=010, a=0xFFFFFFFF, b=2 → md_operator_o=01, md_signed_mode_o=01, md_div_en_o=0, result passed through unchanged.
- DIVU b=0 → md_b_zero_o=1, md_signed_mode_o=00, md_div_en_o held until ready; rsp_data_o=0xFFFFFFFF from engine model.
- Back-pressure: rsp_ready_i=0 for 5 cycles in RESP → rsp_valid_o and rsp_data_o stable, req_ready_o=0; next request accepted only after the handshake cycle.
- flush_i mid-DIV at cycle 10 of 37 → DRAIN, md_div_en_o stays high until md_ready_i, no rsp_valid_o; last_cycles_o=37, then IDLE with req_ready_o=1.
- rst asserted during BUSY → next cycle IDLE, all enables 0, rsp_valid_o=0, last_cycles_o=0; a simultaneous flush_i with req_valid_i in IDLE → request not accepted.

Source files
------------

// File: rtl/zeroriscy_multdiv_ctrl.sv
// zeroriscy_multdiv_ctrl
// Issue-side controller for the zero-riscy multiply/divide engine.
// It accepts one RV32M request and decodes funct3 into the engine's operator
// and signed-mode encoding. Operands and the enable are held steady until the
// engine reports done. The result is then offered to writeback on a
// valid/ready channel.
// A flush never abandons the engine mid-operation. The controller keeps the
// enable high until the engine finishes, then discards the result.

module zeroriscy_multdiv_ctrl #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          op_a_i,
  input  logic [31:0]          op_b_i,
  input  logic                 flush_i,
  output logic                 md_mult_en_o,
  output logic                 md_div_en_o,
  output logic [1:0]           md_operator_o,
  output logic [1:0]           md_signed_mode_o,
  output logic [31:0]          md_op_a_o,
  output logic [31:0]          md_op_b_o,
  output logic                 md_b_zero_o,
  input  logic [31:0]          md_result_i,
  input  logic                 md_ready_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_data_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] last_cycles_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic                 is_mult_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [1:0]           operator_d;
  logic [1:0]           signed_d;
  logic                 engine_active;
  logic                 accept;
  logic                 engine_done;
  logic                 capture;

  assign engine_active = (state_q == BUSY) || (state_q == DRAIN);
  assign accept        = (state_q == IDLE) && req_valid_i && !flush_i;
  assign engine_done   = engine_active && md_ready_i;
  assign capture       = (state_q == BUSY) && md_ready_i && !flush_i;
  assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Translate RV32M funct3 into the engine operator and per-operand signedness
  always_comb begin
    operator_d = 2'b00;
    signed_d   = 2'b00;
    case (funct3_i)
      3'b000: begin operator_d = 2'b00; signed_d = 2'b00; end
      3'b001: begin operator_d = 2'b01; signed_d = 2'b11; end
      3'b010: begin operator_d = 2'b01; signed_d = 2'b01; end
      3'b011: begin operator_d = 2'b01; signed_d = 2'b00; end
      3'b100: begin operator_d = 2'b10; signed_d = 2'b11; end
      3'b101: begin operator_d = 2'b10; signed_d = 2'b00; end
      3'b110: begin operator_d = 2'b11; signed_d = 2'b11; end
      3'b111: begin operator_d = 2'b11; signed_d = 2'b00; end
      default: begin operator_d = 2'b00; signed_d = 2'b00; end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; BUSY/DRAIN leave only on the engine's done pulse or a flush
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) state_d = BUSY;
      end
      BUSY: begin
        if (md_ready_i)   state_d = flush_i ? IDLE : RESP;
        else if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (md_ready_i) state_d = IDLE;
      end
      RESP: begin
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and enable outputs, forced low while reset is held
  always_comb begin
    req_ready_o  = !rst && (state_q == IDLE);
    md_mult_en_o = !rst && engine_active && is_mult_q;
    md_div_en_o  = !rst && engine_active && !is_mult_q;
    rsp_valid_o  = !rst && (state_q == RESP);
    busy_o       = !rst && (state_q != IDLE);
  end

  // Latch the request at accept, count enable cycles, capture the engine result
  always_ff @(posedge clk) begin
    if (rst) begin
      md_op_a_o        <= '0;
      md_op_b_o        <= '0;
      md_operator_o    <= '0;
      md_signed_mode_o <= '0;
      md_b_zero_o      <= 1'b0;
      is_mult_q        <= 1'b0;
      cnt_q            <= '0;
      last_cycles_o    <= '0;
      rsp_data_o       <= '0;
    end else begin
      if (accept) begin
        md_op_a_o        <= op_a_i;
        md_op_b_o        <= op_b_i;
        md_operator_o    <= operator_d;
        md_signed_mode_o <= signed_d;
        md_b_zero_o      <= (op_b_i == 32'd0);
        is_mult_q        <= !funct3_i[2];
        cnt_q            <= '0;
      end else if (engine_active) begin
        cnt_q <= cnt_inc;
      end
      if (engine_done) begin
        last_cycles_o <= cnt_inc;
      end
      if (capture) begin
        rsp_data_o <= md_result_i;
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
// tb_zeroriscy_multdiv_ctrl
// Self-checking bench. The engine model answers after a programmed number of
// enable cycles, using the operator and operands the controller presents.
// Expected results come from a vector table and a scoreboard queue.

module tb_zeroriscy_multdiv_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic        md_b_zero_o;
  logic [31:0] md_result_i;
  logic        md_ready_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        busy_o;
  logic [5:0]  last_cycles_o;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic        bz;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  cycles;
  } exp_t;

  vec_t vecs[11];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   eng_lat = 1;
  int   en_cnt = 0;
  logic force_ready = 1'b0;

  zeroriscy_multdiv_ctrl #(.CNT_WIDTH(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .funct3_i         (funct3_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .flush_i          (flush_i),
    .md_mult_en_o     (md_mult_en_o),
    .md_div_en_o      (md_div_en_o),
    .md_operator_o    (md_operator_o),
    .md_signed_mode_o (md_signed_mode_o),
    .md_op_a_o        (md_op_a_o),
    .md_op_b_o        (md_op_b_o),
    .md_b_zero_o      (md_b_zero_o),
    .md_result_i      (md_result_i),
    .md_ready_i       (md_ready_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .busy_o           (busy_o),
    .last_cycles_o    (last_cycles_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference RV32M arithmetic driven by the operator/signedness the DUT presents
  function automatic logic [31:0] engine_calc(logic [1:0] op, logic [1:0] sm,
                                              logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] rv;
    sa = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
    sb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
    case (op)
      2'b00: begin r = sa * sb; rv = r; return rv[31:0]; end
      2'b01: begin r = sa * sb; rv = r; return rv[63:32]; end
      2'b10: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = sa / sb; rv = r; return rv[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        r = sa % sb; rv = r; return rv[31:0];
      end
    endcase
  endfunction

  // Engine model: done pulse in the eng_lat-th enable cycle, garbage otherwise
  always @(negedge clk) begin
    if (md_mult_en_o || md_div_en_o) begin
      en_cnt = en_cnt + 1;
      if (en_cnt == eng_lat) begin
        md_ready_i  = 1'b1;
        md_result_i = engine_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
      end else begin
        md_ready_i  = force_ready;
        md_result_i = 32'hDEAD_BEEF;
      end
    end else begin
      en_cnt      = 0;
      md_ready_i  = force_ready;
      md_result_i = 32'hDEAD_BEEF;
    end
  end

  // Global time limit so the bench can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] sat6(input int n);
    return (n > 63) ? 6'd63 : 6'(n);
  endfunction

  // Wait for rsp_valid_o while counting enable cycles, with a cycle budget
  task automatic waitRsp(output int cyc);
    int guard;
    cyc = 0;
    guard = 0;
    while (!rsp_valid_o && guard < 300) begin
      if (md_mult_en_o || md_div_en_o) cyc++;
      step();
      guard++;
    end
    checkOutput("rsp_valid_arrives", rsp_valid_o, 1);
  endtask

  // Compare the offered response against the scoreboard head, then complete the handshake
  task automatic respond();
    exp_t e;
    checkOutput("sb_nonempty", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("rsp_data", rsp_data_o, e.data);
      checkOutput("last_cycles", last_cycles_o, e.cycles);
    end
    checkOutput("resp_enables_off", {md_mult_en_o, md_div_en_o}, 0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checkOutput("rsp_valid_after_hs", rsp_valid_o, 0);
    checkOutput("req_ready_after_hs", req_ready_o, 1);
  endtask

  // Issue one table vector and follow it through to the writeback handshake
  task automatic applyStimulus(input vec_t v);
    int cyc;
    checkOutput("req_ready_idle", req_ready_o, 1);
    eng_lat     = v.lat;
    req_valid_i = 1'b1;
    funct3_i    = v.f3;
    op_a_i      = v.a;
    op_b_i      = v.b;
    step();
    req_valid_i = 1'b0;
    op_a_i      = $urandom;
    op_b_i      = $urandom;
    sb_q.push_back('{data: v.res, cycles: sat6(v.lat)});
    checkOutput("busy", busy_o, 1);
    checkOutput("req_ready_busy", req_ready_o, 0);
    checkOutput("operator", md_operator_o, v.op);
    checkOutput("signed_mode", md_signed_mode_o, v.sm);
    checkOutput("b_zero", md_b_zero_o, v.bz);
    checkOutput("mult_en", md_mult_en_o, !v.f3[2]);
    checkOutput("div_en", md_div_en_o, v.f3[2]);
    checkOutput("op_a", md_op_a_o, v.a);
    checkOutput("op_b", md_op_b_o, v.b);
    waitRsp(cyc);
    checkOutput("enable_cycles", cyc, v.lat);
    respond();
  endtask

  initial begin
    int   cyc;
    int   guard;
    logic seen_valid;

    vecs[0]  = '{3'b000, 32'd7,          32'd6,          3,  2'b00, 2'b00, 1'b0, 32'd42};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF,  32'd2,          5,  2'b01, 2'b11, 1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,          4,  2'b01, 2'b01, 1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'd2,          2,  2'b01, 2'b00, 1'b0, 32'd1};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          8,  2'b10, 2'b11, 1'b0, 32'hFFFF_FFFD};
    vecs[5]  = '{3'b101, 32'd100,        32'd0,          6,  2'b10, 2'b00, 1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9,  32'd4,          9,  2'b11, 2'b11, 1'b0, 32'hFFFF_FFFD};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,          5,  2'b11, 2'b00, 1'b0, 32'd2};
    vecs[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  70, 2'b10, 2'b11, 1'b0, 32'h8000_0000};
    vecs[9]  = '{3'b000, 32'h1234_5678,  32'd0,          1,  2'b00, 2'b00, 1'b1, 32'd0};
    vecs[10] = '{3'b110, 32'hFFFF_FFF9,  32'd0,          3,  2'b11, 2'b11, 1'b1, 32'hFFFF_FFF9};

    rst         = 1'b1;
    req_valid_i = 1'b0;
    funct3_i    = 3'b000;
    op_a_i      = 32'd0;
    op_b_i      = 32'd0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b0;
    md_ready_i  = 1'b0;
    md_result_i = 32'd0;

    // Reset state
    step();
    step();
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_enables", {md_mult_en_o, md_div_en_o}, 0);
    checkOutput("rst_rsp_data", rsp_data_o, 0);
    checkOutput("rst_last_cycles", last_cycles_o, 0);
    checkOutput("rst_operands", {md_op_a_o, md_op_b_o}, 0);
    checkOutput("rst_op_sm_bz", {md_operator_o, md_signed_mode_o, md_b_zero_o}, 0);
    rst = 1'b0;
    step();
    checkOutput("idle_req_ready", req_ready_o, 1);

    // Table-driven decode / pass-through / latency vectors
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
    end

    // Back-pressure in RESP with a competing request waiting upstream
    eng_lat = 3;
    req_valid_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd7; op_b_i = 32'd6;
    step();
    sb_q.push_back('{data: 32'd42, cycles: 6'd3});
    funct3_i = 3'b000; op_a_i = 32'd3; op_b_i = 32'd5;
    waitRsp(cyc);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", rsp_valid_o, 1);
      checkOutput("bp_rsp_data", rsp_data_o, 32'd42);
      checkOutput("bp_req_ready", req_ready_o, 0);
      step();
    end
    respond();
    checkOutput("bp_no_same_cycle_accept", busy_o, 0);
    step();
    req_valid_i = 1'b0;
    sb_q.push_back('{data: 32'd15, cycles: 6'd3});
    checkOutput("bp_next_accepted", busy_o, 1);
    checkOutput("bp_next_op_a", md_op_a_o, 32'd3);
    waitRsp(cyc);
    respond();

    // Flush at enable cycle 10 of a 37-cycle divide: drain, no response
    eng_lat = 37;
    req_valid_i = 1'b1; funct3_i = 3'b101; op_a_i = 32'd1000; op_b_i = 32'd7;
    step();
    req_valid_i = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (md_div_en_o) cyc++;
      if (i == 9) flush_i = 1'b1;
      step();
    end
    flush_i = 1'b0;
    checkOutput("drain_busy", busy_o, 1);
    checkOutput("drain_div_en", md_div_en_o, 1);
    checkOutput("drain_rsp_valid", rsp_valid_o, 0);
    guard = 0;
    seen_valid = 1'b0;
    while (busy_o && guard < 200) begin
      if (md_div_en_o) cyc++;
      if (rsp_valid_o) seen_valid = 1'b1;
      step();
      guard++;
    end
    checkOutput("drain_ends", busy_o, 0);
    checkOutput("drain_enable_cycles", cyc, 37);
    checkOutput("drain_no_rsp", seen_valid, 0);
    checkOutput("drain_last_cycles", last_cycles_o, 6'd37);
    checkOutput("drain_req_ready", req_ready_o, 1);

    // Flush coincident with the done pulse in BUSY: discard, straight to IDLE
    eng_lat = 4;
    req_valid_i = 1'b1; funct3_i = 3'b011; op_a_i = 32'd5; op_b_i = 32'd5;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) flush_i = 1'b1;
      step();
    end
    flush_i = 1'b0;
    checkOutput("flushrdy_idle", busy_o, 0);
    checkOutput("flushrdy_rsp_valid", rsp_valid_o, 0);
    checkOutput("flushrdy_last_cycles", last_cycles_o, 6'd4);
    checkOutput("flushrdy_rsp_data_kept", rsp_data_o, 32'd15);

    // Flush in RESP beats rsp_ready_i
    eng_lat = 2;
    req_valid_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9;
    step();
    req_valid_i = 1'b0;
    waitRsp(cyc);
    checkOutput("resp_flush_data", rsp_data_o, 32'd81);
    flush_i = 1'b1;
    rsp_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    rsp_ready_i = 1'b0;
    checkOutput("resp_flush_valid", rsp_valid_o, 0);
    checkOutput("resp_flush_idle", busy_o, 0);

    // A stray done pulse in IDLE is ignored
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    step();
    checkOutput("stray_ready_busy", busy_o, 0);
    checkOutput("stray_ready_valid", rsp_valid_o, 0);
    checkOutput("stray_ready_last", last_cycles_o, 6'd2);

    // Reset while BUSY, then flush with a simultaneous request in IDLE
    eng_lat = 20;
    req_valid_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd11; op_b_i = 32'd13;
    step();
    req_valid_i = 1'b0;
    repeat (3) step();
    checkOutput("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_hold_req_ready", req_ready_o, 0);
    step();
    checkOutput("rst_busy_idle", busy_o, 0);
    checkOutput("rst_busy_enables", {md_mult_en_o, md_div_en_o}, 0);
    checkOutput("rst_busy_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_busy_last", last_cycles_o, 0);
    checkOutput("rst_busy_rsp_data", rsp_data_o, 0);
    checkOutput("rst_busy_op_a", md_op_a_o, 0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_req_ready", req_ready_o, 1);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    checkOutput("flush_blocks_accept", busy_o, 0);
    checkOutput("flush_blocks_op_a", md_op_a_o, 0);

    // Normal operation after everything above
    applyStimulus(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
